// File: rtl/cvxif_issue_initiator.sv
// CV-X-IF issue/commit/result initiator: offloads one decoded instruction at a time and
// tracks writeback IDs. Optional issue-wait timeout is enabled by CVXIF_ISSUE_TIMEOUT_EN.
module cvxif_issue_initiator #(
    parameter int unsigned XLEN           = 32,
    parameter int unsigned NB_OUTSTANDING = 4,
    parameter int unsigned ID_W           = $clog2(NB_OUTSTANDING),
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            instr_valid_i,
    output logic            instr_ready_o,
    input  logic [31:0]     instr_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    input  logic [4:0]      rd_i,
    output logic            issue_valid_o,
    input  logic            issue_ready_i,
    output logic [31:0]     issue_instr_o,
    output logic [XLEN-1:0] issue_rs1_o,
    output logic [XLEN-1:0] issue_rs2_o,
    output logic [ID_W-1:0] issue_id_o,
    input  logic            issue_accept_i,
    input  logic            issue_writeback_i,
    input  logic            issue_exc_i,
    output logic            commit_valid_o,
    output logic [ID_W-1:0] commit_id_o,
    input  logic            result_valid_i,
    output logic            result_ready_o,
    input  logic [ID_W-1:0] result_id_i,
    input  logic [XLEN-1:0] result_data_i,
    input  logic            result_we_i,
    output logic            wb_valid_o,
    output logic [4:0]      wb_rd_o,
    output logic [XLEN-1:0] wb_data_o,
    output logic            illegal_o,
    output logic            busy_o
);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_ISSUE = 1'b1
    } state_e;

    state_e                    state_q, state_d;
    logic [31:0]               instr_q, instr_d;
    logic [XLEN-1:0]           rs1_q, rs1_d;
    logic [XLEN-1:0]           rs2_q, rs2_d;
    logic [4:0]                rd_q, rd_d;
    logic [ID_W-1:0]           id_cnt_q, id_cnt_d;
    logic [NB_OUTSTANDING-1:0] tbl_valid_q, tbl_valid_d;
    logic [4:0]                tbl_rd_q [NB_OUTSTANDING];
    logic [4:0]                tbl_rd_d [NB_OUTSTANDING];
    logic                      commit_valid_q, commit_valid_d;
    logic [ID_W-1:0]           commit_id_q, commit_id_d;
    logic                      wb_valid_q, wb_valid_d;
    logic [4:0]                wb_rd_q, wb_rd_d;
    logic [XLEN-1:0]           wb_data_q, wb_data_d;
    logic                      illegal_q, illegal_d;
    logic                      result_ready_q;
    logic                      full_s;

`ifdef CVXIF_ISSUE_TIMEOUT_EN
    localparam int unsigned WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WAIT_W-1:0]         wait_q, wait_d;
`endif

    // The slot the next accepted writeback would claim is still in use.
    assign full_s = tbl_valid_q[id_cnt_q];

    assign instr_ready_o  = (state_q == S_IDLE) && !full_s;
    assign issue_valid_o  = (state_q == S_ISSUE);
    assign issue_instr_o  = instr_q;
    assign issue_rs1_o    = rs1_q;
    assign issue_rs2_o    = rs2_q;
    assign issue_id_o     = id_cnt_q;
    assign commit_valid_o = commit_valid_q;
    assign commit_id_o    = commit_id_q;
    assign result_ready_o = result_ready_q;
    assign wb_valid_o     = wb_valid_q;
    assign wb_rd_o        = wb_rd_q;
    assign wb_data_o      = wb_data_q;
    assign illegal_o      = illegal_q;
    assign busy_o         = (state_q == S_ISSUE) || (|tbl_valid_q);

    // Next-state, table update and output pulse computation.
    always_comb begin
        state_d        = state_q;
        instr_d        = instr_q;
        rs1_d          = rs1_q;
        rs2_d          = rs2_q;
        rd_d           = rd_q;
        id_cnt_d       = id_cnt_q;
        tbl_valid_d    = tbl_valid_q;
        tbl_rd_d       = tbl_rd_q;
        commit_valid_d = 1'b0;
        commit_id_d    = commit_id_q;
        wb_valid_d     = 1'b0;
        wb_rd_d        = wb_rd_q;
        wb_data_d      = wb_data_q;
        illegal_d      = 1'b0;
`ifdef CVXIF_ISSUE_TIMEOUT_EN
        wait_d         = wait_q;
`endif

        // Results for entries not in use are dropped without side effects.
        if (result_valid_i && tbl_valid_q[result_id_i]) begin
            tbl_valid_d[result_id_i] = 1'b0;
            if (result_we_i) begin
                wb_valid_d = 1'b1;
                wb_rd_d    = tbl_rd_q[result_id_i];
                wb_data_d  = result_data_i;
            end else begin
                wb_valid_d = 1'b0;
            end
        end else begin
            wb_valid_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (instr_valid_i && !full_s) begin
                    instr_d = instr_i;
                    rs1_d   = rs1_i;
                    rs2_d   = rs2_i;
                    rd_d    = rd_i;
                    state_d = S_ISSUE;
`ifdef CVXIF_ISSUE_TIMEOUT_EN
                    wait_d  = '0;
`endif
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ISSUE: begin
                if (issue_ready_i) begin
                    state_d = S_IDLE;
                    // Exceptions are reported later through the result, so exc does not block commit.
                    if (issue_accept_i) begin
                        commit_valid_d = 1'b1;
                        commit_id_d    = id_cnt_q;
                        id_cnt_d       = id_cnt_q + ID_W'(1);
                        if (issue_writeback_i) begin
                            tbl_valid_d[id_cnt_q] = 1'b1;
                            tbl_rd_d[id_cnt_q]    = rd_q;
                        end else begin
                            tbl_valid_d[id_cnt_q] = tbl_valid_q[id_cnt_q];
                        end
                    end else begin
                        illegal_d = 1'b1;
                    end
                end else begin
`ifdef CVXIF_ISSUE_TIMEOUT_EN
                    if (wait_q == WAIT_W'(TIMEOUT_CYCLES - 1)) begin
                        state_d   = S_IDLE;
                        illegal_d = 1'b1;
                    end else begin
                        wait_d = wait_q + WAIT_W'(1);
                    end
`else
                    state_d = S_ISSUE;
`endif
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q        <= S_IDLE;
            instr_q        <= 32'd0;
            rs1_q          <= '0;
            rs2_q          <= '0;
            rd_q           <= 5'd0;
            id_cnt_q       <= '0;
            tbl_valid_q    <= '0;
            tbl_rd_q       <= '{default: 5'd0};
            commit_valid_q <= 1'b0;
            commit_id_q    <= '0;
            wb_valid_q     <= 1'b0;
            wb_rd_q        <= 5'd0;
            wb_data_q      <= '0;
            illegal_q      <= 1'b0;
            result_ready_q <= 1'b1;
`ifdef CVXIF_ISSUE_TIMEOUT_EN
            wait_q         <= '0;
`endif
        end else begin
            state_q        <= state_d;
            instr_q        <= instr_d;
            rs1_q          <= rs1_d;
            rs2_q          <= rs2_d;
            rd_q           <= rd_d;
            id_cnt_q       <= id_cnt_d;
            tbl_valid_q    <= tbl_valid_d;
            tbl_rd_q       <= tbl_rd_d;
            commit_valid_q <= commit_valid_d;
            commit_id_q    <= commit_id_d;
            wb_valid_q     <= wb_valid_d;
            wb_rd_q        <= wb_rd_d;
            wb_data_q      <= wb_data_d;
            illegal_q      <= illegal_d;
            result_ready_q <= 1'b1;
`ifdef CVXIF_ISSUE_TIMEOUT_EN
            wait_q         <= wait_d;
`endif
        end
    end

endmodule

// File: tb/tb_cvxif_issue_initiator.sv
// Self-checking bench for cvxif_issue_initiator: directed scenarios plus a randomized run
// against a transaction-level model of the ID table.
module tb_cvxif_issue_initiator;

    localparam int XLEN = 32;
    localparam int NB   = 4;
    localparam int IDW  = 2;
    localparam int TO   = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic            instr_valid;
    logic            instr_ready;
    logic [31:0]     instr;
    logic [XLEN-1:0] rs1, rs2;
    logic [4:0]      rd;
    logic            issue_valid, issue_ready;
    logic [31:0]     issue_instr;
    logic [XLEN-1:0] issue_rs1, issue_rs2;
    logic [IDW-1:0]  issue_id;
    logic            accept, writeback, exc;
    logic            commit_valid;
    logic [IDW-1:0]  commit_id;
    logic            result_valid, result_ready;
    logic [IDW-1:0]  result_id;
    logic [XLEN-1:0] result_data;
    logic            result_we;
    logic            wb_valid;
    logic [4:0]      wb_rd;
    logic [XLEN-1:0] wb_data;
    logic            illegal, busy;

    int total = 0;
    int bad   = 0;

    cvxif_issue_initiator #(
        .XLEN(XLEN), .NB_OUTSTANDING(NB), .ID_W(IDW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .instr_valid_i(instr_valid), .instr_ready_o(instr_ready),
        .instr_i(instr), .rs1_i(rs1), .rs2_i(rs2), .rd_i(rd),
        .issue_valid_o(issue_valid), .issue_ready_i(issue_ready),
        .issue_instr_o(issue_instr), .issue_rs1_o(issue_rs1), .issue_rs2_o(issue_rs2),
        .issue_id_o(issue_id),
        .issue_accept_i(accept), .issue_writeback_i(writeback), .issue_exc_i(exc),
        .commit_valid_o(commit_valid), .commit_id_o(commit_id),
        .result_valid_i(result_valid), .result_ready_o(result_ready),
        .result_id_i(result_id), .result_data_i(result_data), .result_we_i(result_we),
        .wb_valid_o(wb_valid), .wb_rd_o(wb_rd), .wb_data_o(wb_data),
        .illegal_o(illegal), .busy_o(busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        instr_valid = 1'b0; instr = 32'd0; rs1 = '0; rs2 = '0; rd = 5'd0;
        issue_ready = 1'b0; accept = 1'b0; writeback = 1'b0; exc = 1'b0;
        result_valid = 1'b0; result_id = '0; result_data = '0; result_we = 1'b0;
    endtask

    // Capture then immediately hand over with the given response; no checking here.
    task automatic offload(input logic [31:0] w, input logic [4:0] d, input logic acc, input logic wbk);
        instr_valid = 1'b1; instr = w; rs1 = $urandom; rs2 = $urandom; rd = d;
        tick();
        instr_valid = 1'b0;
        issue_ready = 1'b1; accept = acc; writeback = wbk; exc = 1'b0;
        tick();
        issue_ready = 1'b0; accept = 1'b0; writeback = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        tick();
        total++; if (instr_ready !== 1'b1) begin bad++; $display("FAIL reset_instr_ready got=%b exp=1", instr_ready); end
        total++; if (issue_valid !== 1'b0) begin bad++; $display("FAIL reset_issue_valid got=%b exp=0", issue_valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++; if (result_ready !== 1'b1) begin bad++; $display("FAIL reset_result_ready got=%b exp=1", result_ready); end
        total++; if ({commit_valid, wb_valid, illegal} !== 3'b000) begin bad++; $display("FAIL reset_pulses got=%b exp=000", {commit_valid, wb_valid, illegal}); end
    endtask

    task automatic test_offload_nowb();
        instr_valid = 1'b1; instr = 32'h0000_002B; rs1 = 32'd5; rs2 = 32'd7; rd = 5'd3;
        tick();
        instr_valid = 1'b0;
        total++; if (issue_valid !== 1'b1 || issue_instr !== 32'h2B || issue_rs1 !== 32'd5 || issue_rs2 !== 32'd7)
            begin bad++; $display("FAIL nowb_issue got v=%b i=%h a=%0d b=%0d exp v=1 i=2b a=5 b=7", issue_valid, issue_instr, issue_rs1, issue_rs2); end
        total++; if (issue_id !== 2'd0) begin bad++; $display("FAIL nowb_id got=%0d exp=0", issue_id); end
        total++; if (instr_ready !== 1'b0) begin bad++; $display("FAIL nowb_ready_in_issue got=%b exp=0", instr_ready); end
        issue_ready = 1'b1; accept = 1'b1; writeback = 1'b0;
        tick();
        issue_ready = 1'b0; accept = 1'b0;
        total++; if (commit_valid !== 1'b1 || commit_id !== 2'd0) begin bad++; $display("FAIL nowb_commit got v=%b id=%0d exp v=1 id=0", commit_valid, commit_id); end
        total++; if (issue_valid !== 1'b0 || busy !== 1'b0 || illegal !== 1'b0) begin bad++; $display("FAIL nowb_after got v=%b busy=%b ill=%b exp 0 0 0", issue_valid, busy, illegal); end
        tick();
        total++; if (commit_valid !== 1'b0) begin bad++; $display("FAIL nowb_commit_pulse got=%b exp=0", commit_valid); end
    endtask

    task automatic test_writeback_result();
        logic [XLEN-1:0] a, b;
        a = $urandom; b = $urandom;
        instr_valid = 1'b1; instr = 32'h0000_005B; rs1 = a; rs2 = b; rd = 5'd10;
        tick();
        instr_valid = 1'b0; instr = 32'hFFFF_FFFF; rs1 = ~a; rd = 5'd0;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) begin issue_ready = 1'b1; accept = 1'b1; writeback = 1'b1; end
            total++; if (issue_valid !== 1'b1 || issue_instr !== 32'h5B || issue_rs1 !== a || issue_rs2 !== b || issue_id !== 2'd1)
                begin bad++; $display("FAIL wb_stable cyc=%0d got v=%b i=%h id=%0d exp v=1 i=5b id=1", i, issue_valid, issue_instr, issue_id); end
            tick();
        end
        issue_ready = 1'b0; accept = 1'b0; writeback = 1'b0;
        total++; if (commit_valid !== 1'b1 || commit_id !== 2'd1) begin bad++; $display("FAIL wb_commit got v=%b id=%0d exp v=1 id=1", commit_valid, commit_id); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL wb_busy_entry got=%b exp=1", busy); end
        result_valid = 1'b1; result_id = 2'd1; result_data = 32'hDEAD_BEEF; result_we = 1'b1;
        tick();
        result_valid = 1'b0; result_we = 1'b0;
        total++; if (wb_valid !== 1'b1 || wb_rd !== 5'd10 || wb_data !== 32'hDEAD_BEEF)
            begin bad++; $display("FAIL wb_pulse got v=%b rd=%0d d=%h exp v=1 rd=10 d=deadbeef", wb_valid, wb_rd, wb_data); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL wb_busy_drop got=%b exp=0", busy); end
        tick();
        total++; if (wb_valid !== 1'b0) begin bad++; $display("FAIL wb_single_pulse got=%b exp=0", wb_valid); end
    endtask

    task automatic test_reject();
        instr_valid = 1'b1; instr = 32'h0000_0033; rd = 5'd4;
        tick();
        instr_valid = 1'b0;
        issue_ready = 1'b1; accept = 1'b0; writeback = 1'b1;
        tick();
        issue_ready = 1'b0; writeback = 1'b0;
        total++; if (illegal !== 1'b1 || commit_valid !== 1'b0) begin bad++; $display("FAIL rej_pulse got ill=%b commit=%b exp 1 0", illegal, commit_valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rej_no_alloc got busy=%b exp=0", busy); end
        instr_valid = 1'b1; instr = 32'h0000_000B;
        tick();
        instr_valid = 1'b0;
        total++; if (illegal !== 1'b0) begin bad++; $display("FAIL rej_single_pulse got=%b exp=0", illegal); end
        total++; if (issue_id !== 2'd2) begin bad++; $display("FAIL rej_id_unchanged got=%0d exp=2", issue_id); end
        issue_ready = 1'b1; accept = 1'b1;
        tick();
        issue_ready = 1'b0; accept = 1'b0;
    endtask

    task automatic test_full_wrap();
        test_reset();
        for (int i = 0; i < 4; i++) offload(32'h0000_005B, 5'(20 + i), 1'b1, 1'b1);
        instr_valid = 1'b1; instr = 32'h0000_007B; rd = 5'd9;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (instr_ready !== 1'b0 || issue_valid !== 1'b0) begin bad++; $display("FAIL full_hold got rdy=%b v=%b exp 0 0", instr_ready, issue_valid); end
        end
        result_valid = 1'b1; result_id = 2'd0; result_data = 32'h1234_5678; result_we = 1'b1;
        tick();
        result_valid = 1'b0;
        total++; if (wb_valid !== 1'b1 || wb_rd !== 5'd20 || wb_data !== 32'h1234_5678)
            begin bad++; $display("FAIL full_free_wb got v=%b rd=%0d d=%h exp v=1 rd=20 d=12345678", wb_valid, wb_rd, wb_data); end
        total++; if (instr_ready !== 1'b1) begin bad++; $display("FAIL full_ready_back got=%b exp=1", instr_ready); end
        tick();
        instr_valid = 1'b0;
        total++; if (issue_valid !== 1'b1 || issue_id !== 2'd0) begin bad++; $display("FAIL full_wrap_id got v=%b id=%0d exp v=1 id=0", issue_valid, issue_id); end
        issue_ready = 1'b1; accept = 1'b1; writeback = 1'b0;
        // Back-to-back results on ids 1 and 2, a silent free of id 3, then a stale id 1.
        result_valid = 1'b1; result_id = 2'd1; result_data = 32'hA1; result_we = 1'b1;
        tick();
        issue_ready = 1'b0; accept = 1'b0;
        result_id = 2'd2; result_data = 32'hA2;
        total++; if (wb_valid !== 1'b1 || wb_rd !== 5'd21 || wb_data !== 32'hA1) begin bad++; $display("FAIL b2b_first got v=%b rd=%0d d=%h exp 1 21 a1", wb_valid, wb_rd, wb_data); end
        tick();
        result_id = 2'd3; result_data = 32'hA3; result_we = 1'b0;
        total++; if (wb_valid !== 1'b1 || wb_rd !== 5'd22 || wb_data !== 32'hA2) begin bad++; $display("FAIL b2b_second got v=%b rd=%0d d=%h exp 1 22 a2", wb_valid, wb_rd, wb_data); end
        tick();
        result_id = 2'd1; result_data = 32'hBB; result_we = 1'b1;
        total++; if (wb_valid !== 1'b0) begin bad++; $display("FAIL we0_no_pulse got=%b exp=0", wb_valid); end
        tick();
        result_valid = 1'b0; result_we = 1'b0;
        total++; if (wb_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL stale_result got v=%b busy=%b exp 0 0", wb_valid, busy); end
    endtask

`ifdef CVXIF_ISSUE_TIMEOUT_EN
    task automatic test_timeout();
        test_reset();
        instr_valid = 1'b1; instr = 32'h0000_002B;
        tick();
        instr_valid = 1'b0;
        for (int i = 0; i < TO; i++) begin
            total++; if (issue_valid !== 1'b1 || illegal !== 1'b0) begin bad++; $display("FAIL to_wait cyc=%0d got v=%b ill=%b exp 1 0", i, issue_valid, illegal); end
            tick();
        end
        total++; if (issue_valid !== 1'b0 || illegal !== 1'b1 || instr_ready !== 1'b1)
            begin bad++; $display("FAIL to_expire got v=%b ill=%b rdy=%b exp 0 1 1", issue_valid, illegal, instr_ready); end
        instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
        total++; if (illegal !== 1'b0 || issue_id !== 2'd0) begin bad++; $display("FAIL to_after got ill=%b id=%0d exp 0 0", illegal, issue_id); end
        issue_ready = 1'b1; accept = 1'b1;
        tick();
        issue_ready = 1'b0; accept = 1'b0;
    endtask
`endif

    // Randomized traffic against a model of pending offload, ID counter and writeback table.
    task automatic test_random();
        bit              m_valid [NB];
        logic [4:0]      m_rd [NB];
        int              m_id;
        bit              pending;
        int              waited;
        logic [31:0]     p_instr;
        logic [XLEN-1:0] p_rs1;
        logic [4:0]      p_rd;
        bit              e_commit, e_ill, e_wb, anyv, rdy;
        int              e_cid;
        logic [4:0]      e_wbrd;
        logic [XLEN-1:0] e_wbdata;
        test_reset();
        for (int i = 0; i < NB; i++) begin m_valid[i] = 1'b0; m_rd[i] = 5'd0; end
        m_id = 0; pending = 1'b0; waited = 0; p_instr = 32'd0; p_rs1 = '0; p_rd = 5'd0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            instr_valid  = ($urandom_range(0, 99) < 60);
            instr = $urandom; rs1 = $urandom; rs2 = $urandom; rd = 5'($urandom);
            issue_ready  = ($urandom_range(0, 99) < 35);
            accept       = ($urandom_range(0, 99) < 80);
            writeback    = ($urandom_range(0, 99) < 70);
            exc          = 1'($urandom);
            result_valid = ($urandom_range(0, 99) < 30);
            result_id    = 2'($urandom); result_data = $urandom; result_we = 1'($urandom);
            anyv = 1'b0;
            for (int i = 0; i < NB; i++) anyv |= m_valid[i];
            rdy = !pending && !m_valid[m_id];
            total++; if (instr_ready !== rdy) begin bad++; $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", cyc, instr_ready, rdy); end
            total++; if (issue_valid !== pending) begin bad++; $display("FAIL rnd_issue_valid cyc=%0d got=%b exp=%b", cyc, issue_valid, pending); end
            total++; if (busy !== (pending || anyv)) begin bad++; $display("FAIL rnd_busy cyc=%0d got=%b exp=%b", cyc, busy, pending || anyv); end
            if (pending) begin
                total++; if (issue_id !== 2'(m_id) || issue_instr !== p_instr || issue_rs1 !== p_rs1)
                    begin bad++; $display("FAIL rnd_issue_fields cyc=%0d got id=%0d i=%h exp id=%0d i=%h", cyc, issue_id, issue_instr, m_id, p_instr); end
            end
            e_commit = 1'b0; e_ill = 1'b0; e_wb = 1'b0; e_cid = 0; e_wbrd = 5'd0; e_wbdata = '0;
            if (result_valid && m_valid[result_id]) begin
                m_valid[result_id] = 1'b0;
                if (result_we) begin e_wb = 1'b1; e_wbrd = m_rd[result_id]; e_wbdata = result_data; end
            end
            if (!pending) begin
                if (instr_valid && rdy) begin pending = 1'b1; waited = 0; p_instr = instr; p_rs1 = rs1; p_rd = rd; end
            end else if (issue_ready) begin
                pending = 1'b0;
                if (accept) begin
                    e_commit = 1'b1; e_cid = m_id;
                    if (writeback) begin m_valid[m_id] = 1'b1; m_rd[m_id] = p_rd; end
                    m_id = (m_id + 1) % NB;
                end else e_ill = 1'b1;
            end else begin
`ifdef CVXIF_ISSUE_TIMEOUT_EN
                if (waited == TO - 1) begin pending = 1'b0; e_ill = 1'b1; end
                else waited++;
`endif
            end
            tick();
            total++; if (commit_valid !== e_commit || (e_commit && commit_id !== 2'(e_cid)))
                begin bad++; $display("FAIL rnd_commit cyc=%0d got v=%b id=%0d exp v=%b id=%0d", cyc, commit_valid, commit_id, e_commit, e_cid); end
            total++; if (illegal !== e_ill) begin bad++; $display("FAIL rnd_illegal cyc=%0d got=%b exp=%b", cyc, illegal, e_ill); end
            total++; if (wb_valid !== e_wb || (e_wb && (wb_rd !== e_wbrd || wb_data !== e_wbdata)))
                begin bad++; $display("FAIL rnd_wb cyc=%0d got v=%b rd=%0d d=%h exp v=%b rd=%0d d=%h", cyc, wb_valid, wb_rd, wb_data, e_wb, e_wbrd, e_wbdata); end
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_offload_nowb();
        test_writeback_result();
        test_reject();
        test_full_wrap();
`ifdef CVXIF_ISSUE_TIMEOUT_EN
        test_timeout();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
